sram22_param_sram: RTL and testbench
====================================

SRAM22_PARAM_SRAM -- requirements
Module: sram22_param_sram

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32: word width in bits.
REQ-002 The block SHALL provide parameter ADDR_WIDTH, default 7: address width; RAM_DEPTH = 2^ADDR_WIDTH words.
REQ-003 The block SHALL provide parameter WMASK_WIDTH, default 4: write-mask segments; segment width SEG = DATA_WIDTH/WMASK_WIDTH.
REQ-004 The block SHALL provide parameter READ_LATENCY, default 1: cycles from accepted read to dout_valid; legal values are 1 and 2.
REQ-005 The block SHALL provide parameter CLEAR_ON_RESET, default 1: when 1, the block zero-fills the array after reset.
REQ-006 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL provide port rstb, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL provide port en, input, 1 bit: request valid.
REQ-009 The block SHALL provide port we, input, 1 bit: 1 = write, 0 = read; qualified by en.
REQ-010 The block SHALL provide port wmask, input, WMASK_WIDTH bits: per-segment write enable.
REQ-011 The block SHALL provide port addr, input, ADDR_WIDTH bits: word address.
REQ-012 The block SHALL provide port din, input, DATA_WIDTH bits: write data.
REQ-013 The block SHALL provide port dout, output, DATA_WIDTH bits: read data, registered.
REQ-014 The block SHALL provide port dout_valid, output, 1 bit: one-cycle pulse marking new read data on dout.
REQ-015 The block SHALL provide port busy, output, 1 bit: clear in progress; requests are ignored while it is high.
REQ-016 Elaboration SHALL fail if DATA_WIDTH % WMASK_WIDTH != 0, or if READ_LATENCY is not 1 or 2.

Function
REQ-017 Control SHALL be a two-state FSM, CLEAR and READY; busy = (state == CLEAR).
REQ-018 In CLEAR, each cycle SHALL write all-zero to mem[clr_cnt] and increment clr_cnt.
REQ-019 In CLEAR, after the cycle that writes clr_cnt = RAM_DEPTH-1, the FSM SHALL go to READY; the clear therefore takes exactly RAM_DEPTH cycles.
REQ-020 A request SHALL be accepted only when en=1 and state=READY; en while busy SHALL have no effect on the array, dout or dout_valid.
REQ-021 An accepted write SHALL update, for each k with wmask[k]=1, bits mem[addr][k*SEG +: SEG] = din[k*SEG +: SEG]; unmasked segments are unchanged.
REQ-022 A write with wmask = 0 SHALL leave the array unchanged; writes SHALL never assert dout_valid or change dout.
REQ-023 An accepted read SHALL load mem[addr] into dout and pulse dout_valid exactly READ_LATENCY cycles after the accepting edge.
REQ-024 With READ_LATENCY=2 the read path SHALL use a stage-1 data/valid register followed by the dout/dout_valid output register.
REQ-025 Reads SHALL be fully pipelined: one accepted per cycle, responses in issue order, with no bubbles.
REQ-026 dout SHALL hold its last read value whenever dout_valid=0.
REQ-027 A read accepted on the cycle after a write to the same address SHALL return the newly written data; the single port permits only one operation per cycle.
REQ-028 A write followed by a read issued while an earlier read is in flight SHALL NOT corrupt the in-flight response.

Reset
REQ-029 While rstb=0: dout=0, dout_valid=0, all pipeline valids=0, clr_cnt=0, and state=CLEAR if CLEAR_ON_RESET=1 else READY.
REQ-030 Array contents SHALL NOT be reset asynchronously; with CLEAR_ON_RESET=0 they are preserved across reset.
REQ-031 Reset asserted mid-operation SHALL drop in-flight reads with no dout_valid pulse, and SHALL restart any clear from address 0.
REQ-032 The first rising edge with rstb=1 SHALL begin the clear, or accept requests when CLEAR_ON_RESET=0.

Verification (defaults unless stated)
REQ-033 Release rstb -> busy=1 for exactly 128 cycles, then 0; read addr 5 -> dout=0x00000000 with dout_valid one cycle later.
REQ-034 Write addr 3 din=0xDEADBEEF wmask=4'b1111, then write addr 3 din=0x11223344 wmask=4'b0101, then read addr 3 -> dout=0xDE22BE44.
REQ-035 Write addr 0..3 with 0xA0..0xA3, then read addr 0..3 back-to-back -> dout_valid high 4 consecutive cycles with 0xA0,0xA1,0xA2,0xA3; with READ_LATENCY=2 the same sequence starts one cycle later.
REQ-036 Write addr 7 din=0xFFFFFFFF during clear cycle 10 -> ignored; read addr 7 after busy falls -> 0x00000000.
REQ-037 READ_LATENCY=2: read addr 3 holding 0x12345678, assert rstb=0 on the next cycle -> dout_valid never pulses and dout=0.
REQ-038 CLEAR_ON_RESET=0: write addr 9 din=0xCAFEF00D, pulse rstb -> busy stays 0; read addr 9 -> 0xCAFEF00D.

Source files
------------

// File: rtl/sram22_param_sram.sv
// Single-port SRAM model with masked writes and zero-fill after reset; reads return in READ_LATENCY (1|2) cycles.
// No backpressure: one request per cycle when ready, requests while busy are dropped.
`timescale 1ns/1ps
module sram22_param_sram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 7,
    parameter int WMASK_WIDTH    = 4,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   en,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int SEG       = DATA_WIDTH / WMASK_WIDTH;

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;

    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdat;
    logic [WMASK_WIDTH-1:0] mem_wmask;
    logic                   rd_acc;
    logic [DATA_WIDTH-1:0]  rd_dat;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdat  = din;
        mem_wmask = wmask;
        rd_acc    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdat  = '0;
                mem_wmask = '1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = en && we;
                rd_acc = en && !we;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array has no reset; gating on rstb keeps it untouched while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rstb) begin
            for (int k = 0; k < WMASK_WIDTH; k++) begin
                if (mem_wmask[k]) begin
                    mem[mem_waddr][k*SEG +: SEG] <= mem_wdat[k*SEG +: SEG];
                end
            end
        end
    end

    // Read sees pre-edge contents, so a write on the previous cycle is already visible.
    assign rd_dat = mem[addr];

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_dat_q, s1_dat_d;
        logic                  s1_vld_q, s1_vld_d;

        always_comb begin
            s1_vld_d     = rd_acc;
            s1_dat_d     = rd_acc ? rd_dat : s1_dat_q;
            dout_valid_d = s1_vld_q;
            dout_d       = s1_vld_q ? s1_dat_q : dout_q;
        end

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                s1_vld_q <= 1'b0;
                s1_dat_q <= '0;
            end else begin
                s1_vld_q <= s1_vld_d;
                s1_dat_q <= s1_dat_d;
            end
        end
    end else begin : g_lat1
        always_comb begin
            dout_valid_d = rd_acc;
            dout_d       = rd_acc ? rd_dat : dout_q;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sram22_param_sram.sv
// Directed bench: default instance, READ_LATENCY=2 instance and CLEAR_ON_RESET=0 instance share request inputs.
`timescale 1ns/1ps
module tb_sram22_param_sram;

    logic        clk;
    logic        rstb_a, rstb_b;
    logic        en, we;
    logic [3:0]  wmask;
    logic [6:0]  addr;
    logic [31:0] din;
    logic [31:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        b0, b1, b2;

    int checks = 0;
    int errors = 0;

    sram22_param_sram u0 (
        .clk(clk), .rstb(rstb_a), .en(en), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(d0), .dout_valid(v0), .busy(b0)
    );
    sram22_param_sram #(.READ_LATENCY(2)) u1 (
        .clk(clk), .rstb(rstb_a), .en(en), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(d1), .dout_valid(v1), .busy(b1)
    );
    sram22_param_sram #(.CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .rstb(rstb_b), .en(en), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(d2), .dout_valid(v2), .busy(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        we;
        logic [3:0]  wmask;
        logic [6:0]  addr;
        logic [31:0] din;
        logic        exp_vld;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(input logic e, input logic w, input logic [3:0] m,
                                input logic [6:0] a, input logic [31:0] d,
                                input logic xv, input logic [31:0] xd);
        vec_t v;
        v.en = e; v.we = w; v.wmask = m; v.addr = a; v.din = d;
        v.exp_vld = xv; v.exp_dout = xd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        logic pv;
        logic [31:0] pd;

        rstb_a = 1'b0; rstb_b = 1'b0;
        en = 1'b0; we = 1'b0; wmask = 4'h0; addr = 7'd0; din = 32'h0;

        vt[0]  = mk(1, 0, 4'hF, 7'd5, 32'h0,        1, 32'h00000000);
        vt[1]  = mk(1, 1, 4'hF, 7'd3, 32'hDEADBEEF, 0, 32'h00000000);
        vt[2]  = mk(1, 1, 4'h5, 7'd3, 32'h11223344, 0, 32'h00000000);
        vt[3]  = mk(1, 0, 4'h0, 7'd3, 32'h0,        1, 32'hDE22BE44);
        vt[4]  = mk(1, 1, 4'hF, 7'd0, 32'hA0,       0, 32'hDE22BE44);
        vt[5]  = mk(1, 1, 4'hF, 7'd1, 32'hA1,       0, 32'hDE22BE44);
        vt[6]  = mk(1, 1, 4'hF, 7'd2, 32'hA2,       0, 32'hDE22BE44);
        vt[7]  = mk(1, 1, 4'hF, 7'd3, 32'hA3,       0, 32'hDE22BE44);
        vt[8]  = mk(1, 0, 4'h0, 7'd0, 32'h0,        1, 32'h000000A0);
        vt[9]  = mk(1, 0, 4'h0, 7'd1, 32'h0,        1, 32'h000000A1);
        vt[10] = mk(1, 0, 4'h0, 7'd2, 32'h0,        1, 32'h000000A2);
        vt[11] = mk(1, 0, 4'h0, 7'd3, 32'h0,        1, 32'h000000A3);
        vt[12] = mk(0, 0, 4'h0, 7'd0, 32'h0,        0, 32'h000000A3);
        vt[13] = mk(1, 1, 4'h0, 7'd3, 32'hFFFFFFFF, 0, 32'h000000A3);
        vt[14] = mk(1, 0, 4'h0, 7'd3, 32'h0,        1, 32'h000000A3);
        vt[15] = mk(1, 1, 4'hF, 7'd4, 32'h12345678, 0, 32'h000000A3);
        vt[16] = mk(1, 0, 4'h0, 7'd4, 32'h0,        1, 32'h12345678);
        vt[17] = mk(1, 0, 4'h0, 7'd7, 32'h0,        1, 32'h00000000);
        vt[18] = mk(0, 0, 4'h0, 7'd0, 32'h0,        0, 32'h00000000);

        repeat (3) tick();
        chk("rst_dout0", d0, 32'h0);
        chk("rst_vld0", {31'h0, v0}, 32'h0);
        chk("rst_busy0", {31'h0, b0}, 32'h1);
        chk("rst_dout1", d1, 32'h0);
        chk("rst_vld1", {31'h0, v1}, 32'h0);
        chk("rst_busy1", {31'h0, b1}, 32'h1);
        chk("rst_busy2", {31'h0, b2}, 32'h0);
        chk("rst_dout2", d2, 32'h0);

        // Clear phase, with a write to 7 and a read of 7 thrown at the busy array.
        rstb_a = 1'b1; rstb_b = 1'b1;
        n = 0; seen = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            en = 1'b0; we = 1'b0;
            if (c == 10) begin en = 1'b1; we = 1'b1; wmask = 4'hF; addr = 7'd7; din = 32'hFFFFFFFF; end
            if (c == 11) begin en = 1'b1; we = 1'b0; addr = 7'd7; end
            tick();
            n = c;
            if (v0 || v1) seen = 1'b1;
            if (!b0) break;
        end
        en = 1'b0;
        chk("clear_cycles", 32'(n), 32'd128);
        chk("busy1_after_clear", {31'h0, b1}, 32'h0);
        chk("no_vld_while_busy", {31'h0, seen}, 32'h0);

        // Latency-2 instance trails the latency-1 expectation by exactly one cycle.
        pv = 1'b0; pd = 32'h0;
        for (int i = 0; i < 19; i++) begin
            en = vt[i].en; we = vt[i].we; wmask = vt[i].wmask;
            addr = vt[i].addr; din = vt[i].din;
            tick();
            chk($sformatf("vec%0d_vld_l1", i), {31'h0, v0}, {31'h0, vt[i].exp_vld});
            chk($sformatf("vec%0d_dout_l1", i), d0, vt[i].exp_dout);
            chk($sformatf("vec%0d_vld_l2", i), {31'h0, v1}, {31'h0, pv});
            chk($sformatf("vec%0d_dout_l2", i), d1, pd);
            pv = vt[i].exp_vld; pd = vt[i].exp_dout;
        end
        en = 1'b0;

        // Reset lands while a latency-2 read is in its first stage.
        en = 1'b1; we = 1'b1; wmask = 4'hF; addr = 7'd3; din = 32'h12345678;
        tick();
        we = 1'b0;
        tick();
        en = 1'b0;
        chk("inflight_l1_vld", {31'h0, v0}, 32'h1);
        chk("inflight_l1_dout", d0, 32'h12345678);
        chk("inflight_l2_not_yet", {31'h0, v1}, 32'h0);
        rstb_a = 1'b0;
        #1;
        chk("rst_drop_dout", d1, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (v1) seen = 1'b1;
        end
        chk("rst_drop_no_pulse", {31'h0, seen}, 32'h0);
        chk("rst_drop_dout_held", d1, 32'h0);

        // Reset mid-clear restarts the full sweep.
        rstb_a = 1'b1;
        repeat (20) tick();
        chk("midclear_busy", {31'h0, b0}, 32'h1);
        rstb_a = 1'b0;
        #2;
        rstb_a = 1'b1;
        n = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            n = c;
            if (!b0) break;
        end
        chk("restart_clear_cycles", 32'(n), 32'd128);

        // No-clear instance keeps contents through reset.
        en = 1'b1; we = 1'b1; wmask = 4'hF; addr = 7'd9; din = 32'hCAFEF00D;
        tick();
        en = 1'b0;
        rstb_b = 1'b0;
        #1;
        chk("nc_rst_busy", {31'h0, b2}, 32'h0);
        chk("nc_rst_dout", d2, 32'h0);
        tick();
        rstb_b = 1'b1;
        en = 1'b1; we = 1'b0; addr = 7'd9;
        tick();
        en = 1'b0;
        chk("nc_busy_after", {31'h0, b2}, 32'h0);
        chk("nc_read_vld", {31'h0, v2}, 32'h1);
        chk("nc_read_dout", d2, 32'hCAFEF00D);
        tick();
        chk("nc_vld_drop", {31'h0, v2}, 32'h0);
        chk("nc_dout_hold", d2, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
